// File: rtl/aes_block_sequencer.sv
// Feeds 128-bit blocks through a shared AES-128 core, holding key/direction and returning results via valid/ready.
// Define AES_CBC_EN for CBC chaining (IV + chain registers); leave it undefined for plain ECB.
module aes_block_sequencer #(
    parameter int CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_load,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_inv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         core_start,
    output logic         core_inv,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    input  logic [127:0] core_dout
);
    localparam int CNT_W = $clog2(CORE_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t             state_reg, state_next;
    logic [127:0]       key_reg;
    logic               inv_reg;
    logic [127:0]       blk_reg;
    logic               last_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               start_reg;
    logic [127:0]       out_data_reg;
    logic               out_last_reg;
    logic               out_valid_reg;

    logic               accept;
    logic               cfg_take;
    logic               run_done;
    logic               out_done;
    logic               in_ready_c;

`ifdef AES_CBC_EN
    logic [127:0]       iv_reg;
    logic [127:0]       chain_reg;
`else
    logic               unused_iv;
    assign unused_iv = ^cfg_iv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Config takes priority over a block offered in the same idle cycle.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        cfg_take   = 1'b0;
        run_done   = 1'b0;
        out_done   = 1'b0;
        in_ready_c = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = !cfg_load;
                cfg_take   = cfg_load;
                if (in_valid && !cfg_load) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    run_done   = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg       <= '0;
            inv_reg       <= 1'b0;
            blk_reg       <= '0;
            last_reg      <= 1'b0;
            cnt_reg       <= '0;
            start_reg     <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
`ifdef AES_CBC_EN
            iv_reg        <= '0;
            chain_reg     <= '0;
`endif
        end else begin
            start_reg <= accept;
            if (cfg_take) begin
                key_reg   <= cfg_key;
                inv_reg   <= cfg_inv;
`ifdef AES_CBC_EN
                iv_reg    <= cfg_iv;
                chain_reg <= cfg_iv;
`endif
            end
            if (accept) begin
                blk_reg  <= in_data;
                last_reg <= in_last;
                cnt_reg  <= CNT_W'(CORE_LAT - 1);
            end else if (state_reg == RUN && !run_done) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (run_done) begin
`ifdef AES_CBC_EN
                out_data_reg <= inv_reg ? (core_dout ^ chain_reg) : core_dout;
                chain_reg    <= inv_reg ? blk_reg : core_dout;
`else
                out_data_reg <= core_dout;
`endif
                out_last_reg  <= last_reg;
                out_valid_reg <= 1'b1;
            end
            if (out_done) begin
                out_valid_reg <= 1'b0;
`ifdef AES_CBC_EN
                // A finished message restarts chaining from the stored IV.
                if (out_last_reg) begin
                    chain_reg <= iv_reg;
                end
`endif
            end
        end
    end

`ifdef AES_CBC_EN
    assign core_din = inv_reg ? blk_reg : (blk_reg ^ chain_reg);
`else
    assign core_din = blk_reg;
`endif

    assign in_ready   = in_ready_c && rst_n;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_last_reg;
    assign busy       = (state_reg != IDLE);
    assign core_start = start_reg;
    assign core_inv   = inv_reg;
    assign core_key   = key_reg;

endmodule
